cal_serie: RTL and testbench
============================

// Module: cal_serie
// PURPOSE
//  Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice (cal).
//  Latches two N-bit operands and an op code on start, then feeds the slice one bit per
//  clock, LSB first. It registers the slice's carry back into cin and assembles the
//  N-bit result, final carry and overflow. Handshake: start/busy/done.
// PARAMETERS
//  N  8  operand/result width in bits (N >= 2)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  reset_n    in   1  synchronous, active-low reset
//  start      in   1  request; sampled only in IDLE
//  a          in   N  operand A; latched on accepted start
//  b          in   N  operand B; latched on accepted start
//  op         in   2  00 AND, 01 OR, 10 ADD, 11 SUB (A-B)
//  busy       out  1  high in RUN
//  done       out  1  one-cycle pulse; result, carry and ovf valid from this cycle
//  result     out  N  result register; held until the next accepted start
//  carry      out  1  final carry-out (SUB: 1 = no borrow); 0 for AND/OR
//  ovf        out  1  signed overflow for ADD/SUB (cin_msb ^ cout_msb); 0 for AND/OR
//  cal_a      out  1  to slice a
//  cal_b      out  1  to slice b (B bit inverted for SUB)
//  cal_l      out  1  to slice l; tied 0
//  cal_cin    out  1  to slice cin (carry register)
//  cal_s      out  2  to slice s: AND->00, OR->01, ADD/SUB->10
//  cal_out    in   1  slice result bit; combinational, same cycle
//  cal_c_out  in   1  slice carry-out bit; combinational, same cycle
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge), whatever the state: state=IDLE, busy=0, done=0,
//    result=0, carry=0, ovf=0, cnt=0, carry register=0, shift registers=0.
//  - Reset mid-RUN aborts the operation. The partial result is discarded (result=0).
//  - The cal_* outputs are 0 in IDLE and DONE.
//  - IDLE: on start=1, latch a->sa, b->sb and op; cnt<=0.
//    Carry register <= 1 if op=SUB, else 0. Go to RUN.
//  - RUN: cal_a=sa[0], cal_b=sb[0]^(op==SUB), cal_cin=carry register,
//    cal_s as mapped above. Each edge:
//      - result <= {cal_out, result[N-1:1]}; sa and sb shift right by 1.
//      - Carry register <= cal_c_out for ADD/SUB; stays 0 for AND/OR.
//      - cnt <= cnt+1.
//      - On the edge where cnt=N-1, capture ovf = cal_cin ^ cal_c_out (ADD/SUB only),
//        set carry output = cal_c_out (ADD/SUB only), and go to DONE.
//  - DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
//    start in DONE is ignored.
//  - start while busy or in DONE: ignored, no queueing. a, b and op are don't-care
//    outside an accepted start.
//  - Latency: start accepted at edge t -> RUN for edges t+1..t+N -> done high in the
//    cycle after edge t+N. A new start is accepted no earlier than the edge after done.
//  - Arithmetic is modulo 2^N. cnt width is clog2(N); cnt does not wrap inside RUN.
//  - The slice is combinational. No extra pipeline cycle between cal_* outputs and
//    cal_out/cal_c_out.
// STRUCTURE
//  - Shared package (cal_pkg): op constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10,
//    OP_SUB=2'b11; slice select constants S_AND, S_OR, S_SUM, S_LESS;
//    FSM state encoding ST_IDLE, ST_RUN, ST_DONE.
//  - Single module containing the FSM, counter and shift registers. No sub-module;
//    the cal slice is instantiated beside it at the level above.
//  - The testbench instantiates cal_serie plus cal and wires the cal_* ports together.
// TESTING (N=8, slice cal attached)
//  1. ADD a=0x5A b=0x3C start 1 cycle -> busy 8 cycles, done pulse; result=0x96
//     carry=0 ovf=1.
//  2. ADD a=0xFF b=0x01 -> result=0x00 carry=1 ovf=0.
//  3. SUB a=0x10 b=0x01 -> result=0x0F carry=1 ovf=0; SUB a=0x00 b=0x01 ->
//     result=0xFF carry=0.
//  4. AND a=0xF0 b=0x3C -> 0x30; OR same operands -> 0xFC; carry=0 ovf=0 for both.
//  5. Start pulsed again in RUN cycle 3 with a=0x01 b=0x01 -> ignored; the original
//     result is produced. Result holds after done until the next start.
//  6. reset_n=0 for one edge at RUN cycle 4 -> next cycle busy=0 done=0 result=0
//     cal_*=0. A following ADD 0x01+0x02 gives 0x03.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared constants for the bit-serial sequencer (cal_serie) and its 1-bit ALU slice (cal).
package cal_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [1:0] S_AND  = 2'b00;
  localparam logic [1:0] S_OR   = 2'b01;
  localparam logic [1:0] S_SUM  = 2'b10;
  localparam logic [1:0] S_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // ADD and SUB both use the slice adder; SUB relies on an inverted B and a carry-in of 1.
  function automatic logic [1:0] op_to_sel(input logic [1:0] op);
    logic [1:0] sel;
    sel = S_AND;
    unique case (op)
      OP_AND:         sel = S_AND;
      OP_OR:          sel = S_OR;
      OP_ADD, OP_SUB: sel = S_SUM;
      default:        sel = S_AND;
    endcase
    return sel;
  endfunction

  function automatic logic op_is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cal.sv
// 1-bit combinational ALU slice: AND, OR, full-adder sum, or pass-through of the less input.
module cal
  import cal_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       l,
  input  logic       cin,
  input  logic [1:0] s,
  output logic       out,
  output logic       c_out
);

  always_comb begin
    out = 1'b0;
    unique case (s)
      S_AND:  out = a & b;
      S_OR:   out = a | b;
      S_SUM:  out = a ^ b ^ cin;
      S_LESS: out = l;
      default: out = 1'b0;
    endcase
  end

  assign c_out = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/cal_serie.sv
// Bit-serial sequencer driving a 1-bit ALU slice LSB first; assembles result, carry and overflow.
module cal_serie
  import cal_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         ovf,
  output logic         cal_a,
  output logic         cal_b,
  output logic         cal_l,
  output logic         cal_cin,
  output logic [1:0]   cal_s,
  input  logic         cal_out,
  input  logic         cal_c_out
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    sa_q, sa_d;
  logic [N-1:0]    sb_q, sb_d;
  logic [1:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cin_q, cin_d;
  logic [N-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            arith;

  assign arith = op_is_arith(op_q);

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy     = 1'b0;
    done     = 1'b0;
    cal_a    = 1'b0;
    cal_b    = 1'b0;
    cal_l    = 1'b0;
    cal_cin  = 1'b0;
    cal_s    = S_AND;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          op_d    = op;
          cnt_d   = '0;
          cin_d   = (op == OP_SUB);
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        busy     = 1'b1;
        cal_a    = sa_q[0];
        cal_b    = sb_q[0] ^ (op_q == OP_SUB);
        cal_cin  = cin_q;
        cal_s    = op_to_sel(op_q);
        result_d = {cal_out, result_q[N-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        cin_d    = arith & cal_c_out;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Overflow is the disagreement between carry into and out of the sign bit.
          ovf_d   = arith & (cin_q ^ cal_c_out);
          carry_d = arith & cal_c_out;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_cal_serie.sv
// Scoreboarded bench for cal_serie with the cal slice attached; reference model uses plain integers.
module tb_cal_serie;
  import cal_pkg::*;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         busy, done, carry, ovf;
  logic [N-1:0] result;
  logic         cal_a, cal_b, cal_l, cal_cin, cal_out, cal_c_out;
  logic [1:0]   cal_s;

  typedef struct {
    logic [N-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_run = 0;

  always #5 clk = ~clk;

  cal_serie #(.N(N)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .cal_a     (cal_a),
    .cal_b     (cal_b),
    .cal_l     (cal_l),
    .cal_cin   (cal_cin),
    .cal_s     (cal_s),
    .cal_out   (cal_out),
    .cal_c_out (cal_c_out)
  );

  cal u_cal (
    .a     (cal_a),
    .b     (cal_b),
    .l     (cal_l),
    .cin   (cal_cin),
    .s     (cal_s),
    .out   (cal_out),
    .c_out (cal_c_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Signed/unsigned integer arithmetic, then range tests for carry and overflow.
  function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    e.res = '0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_ADD: begin
        r = ux + uy;
        sr = sx + sy;
        e.res = r[N-1:0];
        e.c = (r >= (1 << N));
        e.v = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
      end
      default: begin
        r = ux - uy;
        sr = sx - sy;
        e.res = r[N-1:0];
        e.c = (ux >= uy);
        e.v = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
      end
    endcase
    return e;
  endfunction

  // Monitor: checks each done against the scoreboard and the RUN length preceding it.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cal_l_zero", {31'd0, cal_l}, 32'd0);
      if (busy) begin
        busy_run++;
      end else begin
        chk("cal_idle_zero", {26'd0, cal_a, cal_b, cal_l, cal_cin, cal_s}, 32'd0);
        if (done) begin
          chk("busy_len", busy_run, N);
          if (expq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("result", {24'd0, result}, {24'd0, e.res});
            chk("carry", {31'd0, carry}, {31'd0, e.c});
            chk("ovf", {31'd0, ovf}, {31'd0, e.v});
          end
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    expq.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    op = 2'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3 * N) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    e = model(o, x, y);
    issue(o, x, y);
    wait_done();
    @(negedge clk);
    chk("result_hold", {24'd0, result}, {24'd0, e.res});
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e5;
    int   done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_carry_ovf", {30'd0, carry, ovf}, 32'd0);

    run_op(OP_ADD, 8'h5A, 8'h3C);
    run_op(OP_ADD, 8'hFF, 8'h01);
    run_op(OP_SUB, 8'h10, 8'h01);
    run_op(OP_SUB, 8'h00, 8'h01);
    run_op(OP_AND, 8'hF0, 8'h3C);
    run_op(OP_OR,  8'hF0, 8'h3C);

    // Start pulsed mid-RUN must be ignored and nothing queued behind it.
    e5 = model(OP_ADD, 8'h77, 8'h19);
    issue(OP_ADD, 8'h77, 8'h19);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'h01;
    b = 8'h01;
    op = OP_ADD;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    done_cnt = 0;
    repeat (3 * N) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("ignored_start_no_done", done_cnt, 0);
    chk("hold_after_ignore", {24'd0, result}, {24'd0, e5.res});

    // Leave carry=1 behind so the reset check below is meaningful.
    run_op(OP_ADD, 8'hFF, 8'h01);
    issue(OP_ADD, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    void'(expq.pop_back());
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_carry_ovf", {30'd0, carry, ovf}, 32'd0);
    chk("abort_cal", {26'd0, cal_a, cal_b, cal_l, cal_cin, cal_s}, 32'd0);
    run_op(OP_ADD, 8'h01, 8'h02);

    for (int i = 0; i < 60; i++) begin
      run_op(2'($urandom), N'($urandom), N'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
